vec_mem_stage: RTL and testbench
================================

Name: vec_mem_stage

Overview:
- Memory-access stage of the vector pipeline. Sits between the EX/MEM pipe register and the MEM/WB pipe register.
- Performs one 192-bit vector load or store per instruction against the 64-bit-wide synchronous data memory, split into 3 beats.
- Stalls the front of the pipeline while beats are in flight. Presents the assembled load word as the memData input of MEM/WB.
- Non-memory instructions pass through with zero added latency.

Parameters:
- DATA_W, 192, vector width in bits (24 x 8-bit lanes).
- BEAT_W, 64, data-memory port width. DATA_W must be an integer multiple of BEAT_W.
- ADDR_W, 21, width of scalar address (matches scalar ALU result width).
- NBEATS, DATA_W/BEAT_W (=3), derived; not overridable.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  EX/MEM holds a live instruction this cycle.
- mem_op  in  2  bit0 = vector load, bit1 = vector store, 00 = no memory access.
- addr  in  ADDR_W  base beat address (scalar ALU result).
- wdata  in  DATA_W  store data (vector register value).
- stall  out  1  freeze IF..EX/MEM and hold the instruction; combinational.
- done  out  1  one-cycle pulse: transfer complete; MEM/WB may capture.
- mem_data  out  DATA_W  assembled load result, registered.
- mem_en  out  1  data-memory enable.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  ADDR_W  data-memory beat address.
- mem_wdata  out  BEAT_W  data-memory write beat.
- mem_rdata  in  BEAT_W  data-memory read beat, valid 1 cycle after address.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- States: IDLE, XFER, DRAIN, DONE. A 2-bit beat counter cnt tracks beats.
- Reset values: state=IDLE, cnt=0, mem_data=0, done=0. mem_en and mem_we are forced 0 combinationally while rst=1.
- Accept: in IDLE with valid=1 and mem_op!=00:
  - latch addr, wdata and op; cnt=0; next state XFER.
  - mem_op=11 is treated as a store (store has priority).
- Pass-through: valid=0 or mem_op=00 leaves state in IDLE. stall=0, done=0, mem_data holds its value.
- XFER, one beat per cycle for NBEATS cycles:
  - mem_en=1, mem_addr = base+cnt (mod 2^ADDR_W, wraps).
  - Store: mem_we=1, mem_wdata = wdata[cnt*BEAT_W +: BEAT_W].
  - Load: mem_we=0.
  - cnt increments each cycle. At cnt=NBEATS-1 the next state is DONE for a store, DRAIN for a load.
- Load capture: mem_rdata is written into mem_data[k*BEAT_W +: BEAT_W] at the end of the cycle after beat k was issued. Beat 0 occupies LSBs.
- DRAIN (load only): mem_en=0. The final beat is captured at the end of this cycle; next state DONE.
- DONE: done=1 for exactly one cycle, stall=0; next state IDLE.
  - In DONE, mem_data is final and stable until the next load's first capture.
  - A new memory instruction presented in DONE is not accepted until the following IDLE cycle.
- stall = (state==IDLE and valid and mem_op!=00) or state==XFER or state==DRAIN.
- Latency, measured from the accept cycle (cycle 0):
  - store: beats in cycles 1-3, done in cycle 4, stall in cycles 0-3.
  - load: beats issued in cycles 1-3, captured at the end of cycles 2-4, done in cycle 5, stall in cycles 0-4.
- Inputs valid, addr, wdata and mem_op are ignored outside IDLE; the latched copies are used.
- Reset mid-transfer: returns to IDLE at the next edge and clears mem_data to 0. No further mem_en pulses occur. A partial store is not rolled back.

Decomposition:
- Package vec_pkg holds:
  - VEC_W=192, BEAT_W=64, SADDR_W=21;
  - enum mem_op_t {MOP_NONE=2'b00, MOP_LOAD=2'b01, MOP_STORE=2'b10};
  - enum vms_state_t {IDLE, XFER, DRAIN, DONE}.
- Sub-module beat_assembler: holds the DATA_W register with per-beat write enable, indexed by a registered copy of cnt, plus clear-on-reset.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> mem_data=0, done=0, stall=0, mem_en=0 for every cycle with rst=1.
- Store: addr=0x00010, wdata={64'hCCCC..., 64'hBBBB..., 64'hAAAA...} -> mem writes 0x10=AAAA, 0x11=BBBB, 0x12=CCCC in cycles 1-3; stall high cycles 0-3; done pulse in cycle 4.
- Load from a memory preloaded at 0x20..0x22 with 1,2,3 -> mem_data = {64'd3, 64'd2, 64'd1}; done in cycle 5; stall high cycles 0-4.
- Address wrap: store at addr=0x1FFFFF -> beats written at 0x1FFFFF, 0x000000, 0x000001.
- mem_op=11 at 0x40 -> behaves as a store (mem_we=1 for 3 beats). mem_op=00 with valid=1 -> stall=0, no mem_en, mem_data unchanged.
- Reset in cycle 2 of a load -> state IDLE next cycle, mem_data=0, no done pulse, mem_en low afterwards. A back-to-back load issued after IDLE completes normally.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and default widths for the vector memory-access stage.
package vec_pkg;

   localparam int VEC_W   = 192;
   localparam int BEAT_W  = 64;
   localparam int SADDR_W = 21;

   typedef enum logic [1:0] {
      MOP_NONE  = 2'b00,
      MOP_LOAD  = 2'b01,
      MOP_STORE = 2'b10
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DRAIN,
      DONE
   } vms_state_t;

endpackage

// File: rtl/beat_assembler.sv
// Collects load beats into the wide result register. Each read beat returns one
// cycle after issue, so the write index is a registered copy of the issue index.
module beat_assembler
   import vec_pkg::*;
#(
   parameter int DATA_W = vec_pkg::VEC_W,
   parameter int BEAT_W = vec_pkg::BEAT_W,
   parameter int IDX_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_i,
   input  logic [IDX_W-1:0]     issue_idx_i,
   input  logic [BEAT_W-1:0]    beat_i,
   output logic [DATA_W-1:0]    data_o
);

   localparam int NBEATS = DATA_W / BEAT_W;

   logic [NBEATS-1:0][BEAT_W-1:0] data_q;
   logic                          cap_q;
   logic [IDX_W-1:0]              idx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q  <= 1'b0;
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         cap_q <= issue_i;
         idx_q <= issue_idx_i;
         if (cap_q) begin
            data_q[idx_q] <= beat_i;
         end
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/vec_mem_stage.sv
// Vector memory-access stage: splits one wide load/store into narrow beats
// against a synchronous data memory, stalling the front of the pipe meanwhile.
//
// state | meaning
// IDLE  | no transfer; accepts a memory op (pass-through otherwise)
// XFER  | issuing one beat per cycle, cnt = beat index
// DRAIN | load only: last read beat returning
// DONE  | one-cycle completion pulse, result stable
module vec_mem_stage
   import vec_pkg::*;
#(
   parameter int DATA_W = vec_pkg::VEC_W,
   parameter int BEAT_W = vec_pkg::BEAT_W,
   parameter int ADDR_W = vec_pkg::SADDR_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid,
   input  logic [1:0]           mem_op,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    wdata,
   output logic                 stall,
   output logic                 done,
   output logic [DATA_W-1:0]    mem_data,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [BEAT_W-1:0]    mem_wdata,
   input  logic [BEAT_W-1:0]    mem_rdata
);

   localparam int NBEATS = DATA_W / BEAT_W;
   localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

   vms_state_t                    state_q;
   logic [CNT_W-1:0]              cnt_q;
   logic                          store_q;
   logic [ADDR_W-1:0]             base_q;
   logic [NBEATS-1:0][BEAT_W-1:0] wdata_q;
   logic                          accept;

   assign accept = (state_q == IDLE) && valid && (mem_op != MOP_NONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= XFER;
                  cnt_q   <= '0;
               end
            end
            XFER: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_BEAT) begin
                  cnt_q   <= '0;
                  state_q <= store_q ? DONE : DRAIN;
               end
            end
            DRAIN:   state_q <= DONE;
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Operands are captured only on accept; bit1 set means store, so 2'b11 stores.
   always_ff @(posedge clk) begin
      if (accept) begin
         base_q  <= addr;
         wdata_q <= wdata;
         store_q <= mem_op[1];
      end
   end

   assign stall     = accept || (state_q == XFER) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign mem_en    = (state_q == XFER) && !rst;
   assign mem_we    = mem_en && store_q;
   assign mem_addr  = base_q + ADDR_W'(cnt_q);
   assign mem_wdata = wdata_q[cnt_q];

   beat_assembler #(
      .DATA_W (DATA_W),
      .BEAT_W (BEAT_W),
      .IDX_W  (CNT_W)
   ) u_asm (
      .clk         (clk),
      .rst         (rst),
      .issue_i     (mem_en && !store_q),
      .issue_idx_i (cnt_q),
      .beat_i      (mem_rdata),
      .data_o      (mem_data)
   );

endmodule

// File: tb/tb_vec_mem_stage.sv
// Self-checking bench for vec_mem_stage: a behavioural data memory plus a
// per-cycle timeline model of stall/done/beat traffic for each operation.
module tb_vec_mem_stage;

   localparam int DW = 192;
   localparam int BW = 64;
   localparam int AW = 21;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid;
   logic [1:0]    mem_op;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          stall;
   logic          done;
   logic [DW-1:0] mem_data;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_wdata;
   logic [BW-1:0] mem_rdata;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] last_load;

   logic [BW-1:0] mem [bit [AW-1:0]];

   always #5 clk = ~clk;

   vec_mem_stage #(.DATA_W(DW), .BEAT_W(BW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .mem_op    (mem_op),
      .addr      (addr),
      .wdata     (wdata),
      .stall     (stall),
      .done      (done),
      .mem_data  (mem_data),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   function automatic logic [BW-1:0] rd(input bit [AW-1:0] a);
      return mem.exists(a) ? mem[a] : '0;
   endfunction

   function automatic logic [DW-1:0] rnd192();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Synchronous data memory: read data appears the cycle after the address.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] = mem_wdata;
         else        mem_rdata <= rd(mem_addr);
      end
   end

   // Drives one op from a negedge with the DUT idle and checks its whole timeline.
   task automatic run_op(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input string tag);
      bit            st;
      int            last;
      bit            e_stall, e_done, e_en;
      logic [AW-1:0] ea;
      logic [DW-1:0] exp_load;
      logic [DW-1:0] exp_md;
      st       = op[1];
      last     = st ? 4 : 5;
      exp_load = {rd(a + 21'd2), rd(a + 21'd1), rd(a)};
      valid  = 1'b1;
      mem_op = op;
      addr   = a;
      wdata  = wd;
      #1;
      for (int c = 0; c <= last; c++) begin
         if (c > 0) @(negedge clk);
         e_stall = (c <= last - 1);
         e_done  = (c == last);
         e_en    = (c >= 1 && c <= 3);
         checks++;
         if (stall !== e_stall) begin
            errors++;
            $display("FAIL %s c%0d stall got %b exp %b", tag, c, stall, e_stall);
         end
         checks++;
         if (done !== e_done) begin
            errors++;
            $display("FAIL %s c%0d done got %b exp %b", tag, c, done, e_done);
         end
         checks++;
         if (mem_en !== e_en) begin
            errors++;
            $display("FAIL %s c%0d mem_en got %b exp %b", tag, c, mem_en, e_en);
         end
         if (e_en) begin
            ea = a + 21'(c - 1);
            checks++;
            if (mem_we !== st) begin
               errors++;
               $display("FAIL %s c%0d mem_we got %b exp %b", tag, c, mem_we, st);
            end
            checks++;
            if (mem_addr !== ea) begin
               errors++;
               $display("FAIL %s c%0d mem_addr got %h exp %h", tag, c, mem_addr, ea);
            end
            if (st) begin
               checks++;
               if (mem_wdata !== wd[(c-1)*BW +: BW]) begin
                  errors++;
                  $display("FAIL %s c%0d mem_wdata got %h exp %h", tag, c, mem_wdata,
                           wd[(c-1)*BW +: BW]);
               end
            end
         end
         if (c == last) begin
            exp_md = st ? last_load : exp_load;
            checks++;
            if (mem_data !== exp_md) begin
               errors++;
               $display("FAIL %s mem_data got %h exp %h", tag, mem_data, exp_md);
            end
            valid  = 1'b0;
            mem_op = 2'b00;
         end else if (c >= 1) begin
            valid  = 1'($urandom());
            mem_op = 2'($urandom());
            addr   = 21'($urandom());
            wdata  = rnd192();
         end
      end
      if (!st) last_load = exp_load;
      if (st) begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd(a + 21'(k)) !== wd[k*BW +: BW]) begin
               errors++;
               $display("FAIL %s memword%0d got %h exp %h", tag, k, rd(a + 21'(k)),
                        wd[k*BW +: BW]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if ({stall, done, mem_en} !== 3'b000) begin
         errors++;
         $display("FAIL %s idle_after stall/done/en got %b exp 000", tag, {stall, done, mem_en});
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      valid  = 1'b0;
      mem_op = 2'b00;
      addr   = '0;
      wdata  = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (mem_data !== '0) begin
            errors++;
            $display("FAIL reset mem_data got %h exp 0", mem_data);
         end
         checks++;
         if ({done, stall, mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset done/stall/en got %b exp 000", {done, stall, mem_en});
         end
      end
      rst       = 1'b0;
      last_load = '0;
   endtask

   task automatic test_store();
      run_op(2'b10, 21'h00010, {{4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}}, "store");
   endtask

   task automatic test_load();
      mem[21'h20] = 64'd1;
      mem[21'h21] = 64'd2;
      mem[21'h22] = 64'd3;
      run_op(2'b01, 21'h00020, rnd192(), "load");
      checks++;
      if (mem_data !== {64'd3, 64'd2, 64'd1}) begin
         errors++;
         $display("FAIL load_const mem_data got %h", mem_data);
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] wd;
      wd = rnd192();
      run_op(2'b10, 21'h1FFFFF, wd, "wrap_st");
      checks++;
      if (rd(21'h000001) !== wd[191:128]) begin
         errors++;
         $display("FAIL wrap_word2 got %h exp %h", rd(21'h000001), wd[191:128]);
      end
      run_op(2'b01, 21'h1FFFFF, rnd192(), "wrap_ld");
      checks++;
      if (mem_data !== wd) begin
         errors++;
         $display("FAIL wrap_readback got %h exp %h", mem_data, wd);
      end
   endtask

   task automatic test_op11();
      run_op(2'b11, 21'h00040, rnd192(), "op11");
   endtask

   task automatic test_passthrough();
      for (int i = 0; i < 4; i++) begin
         valid  = 1'b1;
         mem_op = 2'b00;
         addr   = 21'($urandom());
         wdata  = rnd192();
         #1;
         checks++;
         if (stall !== 1'b0) begin
            errors++;
            $display("FAIL pass stall got %b exp 0", stall);
         end
         @(negedge clk);
         checks++;
         if ({mem_en, done} !== 2'b00) begin
            errors++;
            $display("FAIL pass en/done got %b exp 00", {mem_en, done});
         end
         checks++;
         if (mem_data !== last_load) begin
            errors++;
            $display("FAIL pass mem_data got %h exp %h", mem_data, last_load);
         end
      end
      valid = 1'b0;
   endtask

   task automatic test_random();
      logic [1:0]    op;
      logic [AW-1:0] a;
      for (int i = 0; i < 12; i++) begin
         op = 2'($urandom_range(1, 3));
         a  = (i % 4 == 3) ? 21'h1FFFFE : 21'h100 + 21'($urandom_range(0, 7));
         run_op(op, a, rnd192(), "rand");
      end
   endtask

   task automatic test_reset_mid_load();
      mem[21'h300] = 64'h1111_2222_3333_4444;
      mem[21'h301] = 64'h5555_6666_7777_8888;
      mem[21'h302] = 64'h9999_AAAA_BBBB_CCCC;
      valid  = 1'b1;
      mem_op = 2'b01;
      addr   = 21'h300;
      @(negedge clk);
      valid  = 1'b0;
      mem_op = 2'b00;
      checks++;
      if (mem_en !== 1'b1) begin
         errors++;
         $display("FAIL rstmid c1 mem_en got %b exp 1", mem_en);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (mem_en !== 1'b0) begin
         errors++;
         $display("FAIL rstmid c2 mem_en got %b exp 0", mem_en);
      end
      @(negedge clk);
      checks++;
      if (mem_data !== '0) begin
         errors++;
         $display("FAIL rstmid mem_data got %h exp 0", mem_data);
      end
      rst       = 1'b0;
      last_load = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_en, done, stall} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid after%0d en/done/stall got %b exp 000", i, {mem_en, done, stall});
         end
      end
   endtask

   task automatic test_back_to_back();
      run_op(2'b01, 21'h300, rnd192(), "b2b_ld");
      run_op(2'b10, 21'h310, rnd192(), "b2b_st");
      run_op(2'b01, 21'h310, rnd192(), "b2b_ld2");
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_wrap();
      test_op11();
      test_passthrough();
      test_random();
      test_reset_mid_load();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
